systolic_seq: RTL and testbench
===============================

# systolic_seq

Sequencer for the N×N weight-stationary PE array.
- Accepts one matmul command.
- Loads array weights one row at a time from the weight buffer.
- Drives the global PE `start` for exactly the fill + stream + drain window.
- Emits per-row skewed feed strobes and per-column output-valid strobes so the input and output buffers stay cycle-aligned with the array.

## Interface
Parameters:
- N, 2, array dimension (rows = columns), ≥2
- CNT_W, 8, width of vector count

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high; = (state==IDLE) & ~abort
- cmd_num_vec  in  CNT_W  input vectors to stream; 0 allowed
- cmd_reuse_w  in  1  skip weight load if weights currently valid
- abort  in  1  synchronous cancel
- wt_rd_en  out  1  weight buffer read strobe
- wt_rd_addr  out  $clog2(N)  weight row index; buffer returns data next cycle
- load_weight  out  N  one-hot per-row PE load_weight
- pe_start  out  1  global PE start
- feed_valid  out  N  row i input buffer presents element this cycle
- out_valid  out  N  column j bottom psum valid this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
States: IDLE, LOAD, COMPUTE, DONE.

- **IDLE**
  - Accept on cmd_valid & cmd_ready; latch num_vec.
  - Go to LOAD if ~cmd_reuse_w or ~wts_valid, else COMPUTE.
  - If num_vec==0 and load skipped, go to DONE.
- **LOAD**: N+1 cycles, local index k.
  - Cycles k=0..N-1: wt_rd_en=1, wt_rd_addr=k.
  - Cycles k=1..N: load_weight=1<<(k-1).
  - Sets wts_valid at exit.
  - Exits to COMPUTE, or to DONE if num_vec==0.
- **COMPUTE**: num_vec+2N-1 cycles, first cycle = t0, cycle offset c.
  - pe_start=1 for c=0..num_vec+2N-3.
  - feed_valid[i]=1 for i ≤ c < i+num_vec.
  - out_valid[j]=1 for N+j ≤ c < N+j+num_vec.
- **DONE**: done=1 for one cycle, then IDLE.

Invariants:
- load_weight and pe_start are never high in the same cycle; the PE gives load_weight priority, so overlap would stall streaming.
- wts_valid is cleared by rst and by abort.
- **Abort**:
  - In any non-IDLE state, the next cycle is IDLE.
  - All strobes are 0 from that cycle; no done pulse.
  - Ignored in IDLE, but it masks cmd_ready that cycle.
- **Async rst mid-operation**: immediate IDLE, all strobes 0, wts_valid=0.
- Counters: CNT_W+2 bits, so num_vec+2N-1 never wraps. Latched num_vec is held for the whole command.

## Timing
Reset values:
- cmd_ready=1 (IDLE, abort low).
- All other outputs 0: wt_rd_en, wt_rd_addr, load_weight, pe_start, feed_valid, out_valid, busy, done.

Latencies and ordering:
- Accept edge ends cycle a.
- LOAD occupies a+1..a+N+1; t0 = a+N+2. With reuse, t0 = a+1.
- Column j of vector v is valid at t0+N+j+v.
- done at t0+num_vec+2N-1; cmd_ready again the following cycle.
- No back-to-back overlap: a new command is accepted only in IDLE.
- All outputs are registered except cmd_ready.

## Structure
- Shared package tpu_pkg holds:
  - seq_state_t enum (IDLE, LOAD, COMPUTE, DONE)
  - default N / CNT_W localparams
  - window-length helper function (num_vec+2N-1)
- Single module; one shared phase counter reused by LOAD and COMPUTE.
- Window compares are per-row/column generate loops; no sub-module required.

## Test plan
All scenarios use N=2.
1. **Reset**: rst pulse mid-COMPUTE → all outputs 0 immediately; cmd_ready=1 after release; next cmd_reuse_w=1 still performs LOAD.
2. **Full command**: num_vec=3 accepted cycle 0 →
   - wt_rd_en cycles 1–2 (addr 0, 1)
   - load_weight 01@2, 10@3
   - pe_start 4–8
   - feed_valid[0] 4–6, feed_valid[1] 5–7
   - out_valid[0] 6–8, out_valid[1] 7–9
   - done@10; cmd_ready@11
3. **Reuse**: after scenario 2, num_vec=1, cmd_reuse_w=1, accept cycle 0 →
   - no wt_rd_en
   - pe_start 1–3
   - out_valid[0]@3, out_valid[1]@4
   - done@5
4. **Zero vectors**: num_vec=0, reuse=0 → LOAD as normal, no pe_start, done 4 cycles after accept.
5. **Abort**: abort in COMPUTE cycle t0+2 → all strobes 0 at t0+3, no done, busy=0; later reuse command reloads weights.
6. **Abort masking**: cmd_valid and abort high together in IDLE → cmd_ready=0, command not taken. Also check load_weight & pe_start is never 1 over random command streams.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the weight-stationary PE array control path:
// sequencer state encoding, default array geometry, and the compute
// window length shared by the sequencer and anything that schedules
// around it.
package tpu_pkg;

   localparam int N_DEF     = 2;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2,
      DONE    = 2'd3
   } seq_state_t;

   // Cycles spent in COMPUTE: fill (N-1) + stream (num_vec) + drain (N).
   function automatic int unsigned win_len(input int unsigned num_vec,
                                           input int unsigned n);
      return num_vec + 2 * n - 1;
   endfunction

endpackage

// File: rtl/systolic_seq.sv
// Sequencer for the N x N weight-stationary PE array. Takes one matmul
// command, loads the weights row by row (unless they can be reused),
// then runs the fill/stream/drain window with per-row feed strobes and
// per-column output-valid strobes. All outputs except cmd_ready are
// registered: the next-cycle values are derived from the next state and
// the next phase count, so every strobe lines up with its own cycle.
module systolic_seq
   import tpu_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [CNT_W-1:0]     cmd_num_vec,
   input  logic                 cmd_reuse_w,
   input  logic                 abort,
   output logic                 wt_rd_en,
   output logic [$clog2(N)-1:0] wt_rd_addr,
   output logic [N-1:0]         load_weight,
   output logic                 pe_start,
   output logic [N-1:0]         feed_valid,
   output logic [N-1:0]         out_valid,
   output logic                 busy,
   output logic                 done
);

   localparam int AW = $clog2(N);
   // Two extra bits so num_vec + 2N - 1 can never wrap the phase counter.
   localparam int CW = CNT_W + 2;

   seq_state_t       state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [CNT_W-1:0] num_vec, nv_nxt;
   logic             wts_valid, wts_nxt;
   logic             accept;

   logic [CW-1:0]    win_last_cur;
   logic [CW-1:0]    win_last_nxt;
   logic [CW-1:0]    nv_ext;

   logic             rd_en_nxt;
   logic [AW-1:0]    addr_nxt;
   logic [N-1:0]     lw_nxt;
   logic             pe_nxt;
   logic [N-1:0]     fv_nxt;
   logic [N-1:0]     ov_nxt;
   logic             busy_nxt;
   logic             done_nxt;

   // Abort masks acceptance even though it is otherwise ignored in IDLE.
   assign cmd_ready = (state == IDLE) & ~abort;
   assign accept    = cmd_valid & cmd_ready;

   // Last phase index of COMPUTE for the command in flight (cur) and for
   // the command that will be in flight next cycle (nxt).
   assign win_last_cur = CW'(win_len(32'(num_vec), N) - 32'd1);
   assign win_last_nxt = CW'(win_len(32'(nv_nxt), N) - 32'd1);
   assign nv_ext       = CW'(nv_nxt);

   // Next state, shared phase counter, latched vector count and weight-valid flag.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      nv_nxt    = num_vec;
      wts_nxt   = wts_valid;
      case (state)
         IDLE: begin
            if (accept) begin
               nv_nxt  = cmd_num_vec;
               cnt_nxt = '0;
               if (!cmd_reuse_w || !wts_valid)
                  state_nxt = LOAD;
               else if (cmd_num_vec == '0)
                  state_nxt = DONE;
               else
                  state_nxt = COMPUTE;
            end
         end
         LOAD: begin
            if (cnt == CW'(N)) begin
               wts_nxt   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = (num_vec == '0) ? DONE : COMPUTE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         COMPUTE: begin
            if (cnt == win_last_cur)
               state_nxt = DONE;
            else
               cnt_nxt = cnt + 1'b1;
         end
         DONE: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end
      if (abort)
         wts_nxt = 1'b0;
   end

   // Scalar strobes for the coming cycle, decoded from next state and phase.
   always_comb begin
      rd_en_nxt = (state_nxt == LOAD) && (cnt_nxt < CW'(N));
      addr_nxt  = rd_en_nxt ? cnt_nxt[AW-1:0] : '0;
      pe_nxt    = (state_nxt == COMPUTE) && (cnt_nxt < win_last_nxt);
      busy_nxt  = (state_nxt != IDLE);
      done_nxt  = (state_nxt == DONE);
   end

   // Per-row/column windows: weight row i loads one cycle after its read,
   // row i feeds for num_vec cycles starting at phase i, column j emits
   // for num_vec cycles starting at phase N+j.
   for (genvar i = 0; i < N; i++) begin : g_lane
      assign lw_nxt[i] = (state_nxt == LOAD) && (cnt_nxt == CW'(i + 1));
      assign fv_nxt[i] = (state_nxt == COMPUTE) &&
                         (cnt_nxt >= CW'(i)) && (cnt_nxt < CW'(i) + nv_ext);
      assign ov_nxt[i] = (state_nxt == COMPUTE) &&
                         (cnt_nxt >= CW'(N + i)) && (cnt_nxt < CW'(N + i) + nv_ext);
   end

   // Control state and registered outputs; async reset drops everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         wts_valid   <= 1'b0;
         wt_rd_en    <= 1'b0;
         wt_rd_addr  <= '0;
         load_weight <= '0;
         pe_start    <= 1'b0;
         feed_valid  <= '0;
         out_valid   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         wts_valid   <= wts_nxt;
         wt_rd_en    <= rd_en_nxt;
         wt_rd_addr  <= addr_nxt;
         load_weight <= lw_nxt;
         pe_start    <= pe_nxt;
         feed_valid  <= fv_nxt;
         out_valid   <= ov_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
      end
   end

   // Latched vector count is datapath-like and only meaningful while busy.
   always_ff @(posedge clk) begin
      num_vec <= nv_nxt;
   end

endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq (N=2). A schedule model expands every accepted
// command into a per-cycle list of expected outputs (load rows, compute
// window, done pulse); abort and reset discard the rest of the list.
module tb_systolic_seq;

   localparam int N     = 2;
   localparam int CNT_W = 8;
   localparam int AW    = $clog2(N);

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_num_vec;
   logic             cmd_reuse_w;
   logic             abort;
   logic             wt_rd_en;
   logic [AW-1:0]    wt_rd_addr;
   logic [N-1:0]     load_weight;
   logic             pe_start;
   logic [N-1:0]     feed_valid;
   logic [N-1:0]     out_valid;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_errors = 0;

   systolic_seq #(.N(N), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_num_vec (cmd_num_vec),
      .cmd_reuse_w (cmd_reuse_w),
      .abort       (abort),
      .wt_rd_en    (wt_rd_en),
      .wt_rd_addr  (wt_rd_addr),
      .load_weight (load_weight),
      .pe_start    (pe_start),
      .feed_valid  (feed_valid),
      .out_valid   (out_valid),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          busy;
      logic          rd_en;
      logic [AW-1:0] addr;
      logic [N-1:0]  lw;
      logic          pe;
      logic [N-1:0]  fv;
      logic [N-1:0]  ov;
      logic          done;
      logic          set_wts;
   } exp_t;

   exp_t sched[$];
   bit   wts_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expand one accepted command into its per-cycle expected outputs.
   function automatic void build(input int nv, input bit load);
      exp_t e;
      if (load) begin
         for (int k = 0; k <= N; k++) begin
            e         = '0;
            e.busy    = 1'b1;
            e.rd_en   = (k < N);
            if (k < N) e.addr = k[AW-1:0];
            if (k >= 1) e.lw[k-1] = 1'b1;
            e.set_wts = (k == N);
            sched.push_back(e);
         end
      end
      if (nv > 0) begin
         for (int c = 0; c < nv + 2 * N - 1; c++) begin
            e      = '0;
            e.busy = 1'b1;
            e.pe   = (c < nv + 2 * N - 2);
            for (int i = 0; i < N; i++) begin
               e.fv[i] = (c >= i) && (c < i + nv);
               e.ov[i] = (c >= N + i) && (c < N + i + nv);
            end
            sched.push_back(e);
         end
      end
      e      = '0;
      e.busy = 1'b1;
      e.done = 1'b1;
      sched.push_back(e);
   endfunction

   // One clock cycle: drive inputs, sample mid-cycle, compare, advance model.
   task automatic step(input logic cv, input logic [CNT_W-1:0] nv, input logic ru,
                       input logic ab, output logic acc, output logic dn);
      exp_t cur;
      logic exp_ready;
      @(posedge clk);
      #1;
      cmd_valid   = cv;
      cmd_num_vec = nv;
      cmd_reuse_w = ru;
      abort       = ab;
      @(negedge clk);
      cur = '0;
      if (sched.size() > 0) cur = sched.pop_front();
      chk("busy",        busy,        cur.busy);
      chk("wt_rd_en",    wt_rd_en,    cur.rd_en);
      chk("wt_rd_addr",  wt_rd_addr,  cur.addr);
      chk("load_weight", load_weight, cur.lw);
      chk("pe_start",    pe_start,    cur.pe);
      chk("feed_valid",  feed_valid,  cur.fv);
      chk("out_valid",   out_valid,   cur.ov);
      chk("done",        done,        cur.done);
      exp_ready = !cur.busy && !ab;
      chk("cmd_ready",   cmd_ready,   exp_ready);
      chk("lw_pe_overlap", (|load_weight) & pe_start, 1'b0);
      dn = done;
      if (ab) begin
         wts_m = 1'b0;
         if (cur.busy) sched.delete();
      end else if (cur.set_wts) begin
         wts_m = 1'b1;
      end
      acc = cv && exp_ready;
      if (acc) build(int'(nv), !ru || !wts_m);
   endtask

   // Issue one command from IDLE and return the cycle of its done pulse
   // relative to the accept cycle (-1 if none within the budget).
   task automatic run_cmd(input int nv, input logic ru, input int abort_at, output int dcyc);
      logic acc, dn;
      dcyc = -1;
      step(1'b1, CNT_W'(nv), ru, 1'b0, acc, dn);
      for (int i = 1; i < 200; i++) begin
         step(1'b0, '0, 1'b0, (i == abort_at), acc, dn);
         if (dn) begin
            dcyc = i;
            break;
         end
         if (abort_at > 0 && i > abort_at + 3) break;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rd_en"}, wt_rd_en,    1'b0);
      chk({tag, "_addr"},  wt_rd_addr,  '0);
      chk({tag, "_lw"},    load_weight, '0);
      chk({tag, "_pe"},    pe_start,    1'b0);
      chk({tag, "_fv"},    feed_valid,  '0);
      chk({tag, "_ov"},    out_valid,   '0);
      chk({tag, "_busy"},  busy,        1'b0);
      chk({tag, "_done"},  done,        1'b0);
      chk({tag, "_ready"}, cmd_ready,   1'b1);
   endtask

   initial begin
      int   dcyc;
      logic acc, dn;

      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_num_vec = '0;
      cmd_reuse_w = 1'b0;
      abort       = 1'b0;
      #3;
      check_all_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;

      // Full command with weight load.
      run_cmd(3, 1'b0, -1, dcyc);
      chk("full_done_cycle", dcyc, 10);

      // Weight reuse skips LOAD.
      run_cmd(1, 1'b1, -1, dcyc);
      chk("reuse_done_cycle", dcyc, 5);

      // Zero vectors still loads, no compute window.
      run_cmd(0, 1'b0, -1, dcyc);
      chk("zero_done_cycle", dcyc, 4);

      // Abort at t0+2 of a reuse command: no done, weights invalidated.
      run_cmd(3, 1'b1, 3, dcyc);
      chk("abort_no_done", dcyc, -1);
      run_cmd(1, 1'b1, -1, dcyc);
      chk("after_abort_reload", dcyc, 8);

      // Async reset in the middle of COMPUTE.
      step(1'b1, 8'd3, 1'b0, 1'b0, acc, dn);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0, acc, dn);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_all_zero("midrst");
      sched.delete();
      wts_m = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      run_cmd(1, 1'b1, -1, dcyc);
      chk("after_rst_reload", dcyc, 8);

      // Abort masks acceptance in IDLE.
      step(1'b1, 8'd2, 1'b0, 1'b1, acc, dn);
      step(1'b0, '0, 1'b0, 1'b0, acc, dn);
      chk("abort_mask_busy", busy, 1'b0);

      // Random command stream with occasional aborts.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 2) == 0),
              CNT_W'($urandom_range(0, 6)),
              $urandom_range(0, 1) == 1,
              ($urandom_range(0, 9) == 0),
              acc, dn);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
